buzz_arbiter: RTL and testbench
===============================

Name: buzz_arbiter

Overview:
- Upstream stage of Score_design in the responder system.
- Arms a quiz round, registers the first player to buzz, and locks out all other players.
- Runs a per-answer countdown and turns the host's judge buttons, or a timeout, into single-cycle correct/wrong pulses.
- Its player, if_correct, if_wrong and enable outputs drive Score_design directly; timer_sec and state drive seg7.

Parameters:
- N_PLAYERS, 4: number of buzzer inputs; sets the player vector width.
- CLK_HZ, 100_000_000: clock cycles per one-second tick.
- ANSWER_SEC, 10: answer countdown start value in seconds, range 1..99.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_btn  in  1  host arms a round; level input, edge-detected internally.
- buzz  in  N_PLAYERS  player buttons, debounced upstream; level inputs.
- correct_btn  in  1  host judges the answer correct; level input.
- wrong_btn  in  1  host judges the answer wrong; level input.
- player  out  N_PLAYERS  one-hot answering player; 0 means none.
- if_correct  out  1  one-cycle pulse.
- if_wrong  out  1  one-cycle pulse.
- enable  out  1  high while a player holds the floor (LOCKED).
- timer_sec  out  8  remaining answer seconds, binary.
- state  out  2  FSM state code for the display.

Behaviour:
- Input conditioning: every button passes through a 2-FF synchronizer, then a rising-edge detector. Only edges act, which gives 3 cycles of latency from pin to action.
- Reset values: player=0, if_correct=0, if_wrong=0, enable=0, timer_sec=0, state=IDLE. Reset mid-round aborts it with no pulse emitted.
- State encoding: IDLE=0, ARMED=1, LOCKED=2, DONE=3.
- IDLE:
  - A start edge moves to ARMED.
  - Buzz edges are ignored.
- ARMED:
  - The first cycle with any buzz edge latches the winner and moves to LOCKED.
  - Simultaneous edges: the lowest index wins.
  - On that transition: player=onehot(winner), timer_sec=ANSWER_SEC, tick counter cleared, enable=1 on the next cycle.
  - A start edge in ARMED is ignored.
- LOCKED:
  - The tick counter counts 0..CLK_HZ-1. At wrap, timer_sec decrements.
  - Reaching timer_sec=0 forces a wrong verdict.
  - A correct edge gives if_correct=1 for one cycle.
  - A wrong edge or a timeout gives if_wrong=1 for one cycle.
  - Correct and wrong in the same cycle: wrong wins.
  - Timeout and a judge edge in the same cycle: the judge edge decides.
  - After any verdict, go to DONE with enable=0. player stays valid during the pulse cycle.
  - Further buzz edges and start edges are ignored.
- DONE:
  - player holds until the next start edge.
  - A start edge clears player and timer_sec and goes to ARMED, which enables back-to-back rounds.
  - Judge edges are ignored.
- Pulse guarantee: exactly one verdict pulse per LOCKED episode, never both.
- Width rules: the tick counter is $clog2(CLK_HZ) bits. timer_sec saturates at 0 and never wraps.

Optional Feature:
- Macro: BUZZ_FOUL_EN.
- Defined:
  - A buzz edge while IDLE sets that player's bit in a foul mask, cleared by the next start→ARMED transition's completion (end of round) or by rst.
  - Fouled players are masked out of arbitration in ARMED.
  - Extra output foul_mask[N_PLAYERS-1:0], reset 0.
- Undefined: no mask, no foul_mask port, and IDLE buzzes are simply ignored.

Decomposition:
- Package buzz_pkg holds:
  - the state enum with codes IDLE/ARMED/LOCKED/DONE;
  - the STATE_W=2 constant;
  - a priority-to-one-hot function.
- One sub-module, btn_edge: a 2-FF synchronizer plus rising-edge detector, instantiated per button or per vector.

Test Plan (CLK_HZ=10, ANSWER_SEC=3):
1. rst, start edge, then buzz=0100 → state=LOCKED, player=0100 and enable=1 within 4 cycles; correct edge → if_correct pulse 1 cycle, state=DONE, player still 0100.
2. Armed, then buzz=0110 in the same cycle → player=0010; later buzz=0001 edge → ignored, player unchanged.
3. LOCKED with no judge → timer_sec steps 3,2,1,0 at 10-cycle intervals; at 0, if_wrong pulses once and state=DONE.
4. LOCKED, correct_btn and wrong_btn rise together → if_wrong=1 and if_correct=0.
5. rst asserted mid-LOCKED → next cycle all outputs are at reset values and no pulses appear.
6. With BUZZ_FOUL_EN: buzz=0001 in IDLE, start, buzz=0011 → foul_mask=0001, player=0010.

Source files
------------

// File: rtl/buzz_pkg.sv
// buzz_pkg: shared state codes and helpers for the quiz buzzer arbiter
package buzz_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Keeps only the lowest set bit, so the lowest player index wins ties
    function automatic logic [31:0] prio_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/buzz_arbiter_btn_edge.sv
// btn_edge: two-flop synchronizer followed by a rising-edge detector, per bit
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_btn,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_s1, r_s2, r_prev;

    // Synchronize the raw levels and remember the previous synchronized level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_rise = r_s2 & ~r_prev;

endmodule

// File: rtl/buzz_arbiter.sv
// buzz_arbiter: first-buzz lockout, answer countdown and verdict pulses (optional foul mask via BUZZ_FOUL_EN)
module buzz_arbiter import buzz_pkg::*; #(
    parameter int N_PLAYERS  = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int ANSWER_SEC = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_btn,
    input  logic [N_PLAYERS-1:0] buzz,
    input  logic                 correct_btn,
    input  logic                 wrong_btn,
    output logic [N_PLAYERS-1:0] player,
    output logic                 if_correct,
    output logic                 if_wrong,
    output logic                 enable,
    output logic [7:0]           timer_sec,
    output logic [STATE_W-1:0]   state
`ifdef BUZZ_FOUL_EN
    ,
    output logic [N_PLAYERS-1:0] foul_mask
`endif
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    state_t                r_state, w_next;
    logic [N_PLAYERS-1:0]  r_player;
    logic [7:0]            r_timer;
    logic [TICK_W-1:0]     r_tick;
    logic                  r_correct, r_wrong;
    logic [N_PLAYERS+2:0]  w_edge;
    logic                  w_start, w_corr, w_wrong, w_timeout, w_verdict;
    logic                  w_set_correct, w_set_wrong;
    logic [N_PLAYERS-1:0]  w_buzz, w_cand, w_win;

    btn_edge #(.W(N_PLAYERS + 3)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .i_btn ({start_btn, correct_btn, wrong_btn, buzz}),
        .o_rise(w_edge)
    );

    assign w_start   = w_edge[N_PLAYERS+2];
    assign w_corr    = w_edge[N_PLAYERS+1];
    assign w_wrong   = w_edge[N_PLAYERS];
    assign w_buzz    = w_edge[N_PLAYERS-1:0];
    assign w_timeout = (r_timer == 8'd0);
    assign w_verdict = w_corr | w_wrong | w_timeout;
    assign w_win     = N_PLAYERS'(prio_onehot(32'(w_cand)));

`ifdef BUZZ_FOUL_EN
    logic [N_PLAYERS-1:0] r_foul;

    // Players who buzz before the round is armed are barred until the round ends
    always_ff @(posedge clk) begin
        if (rst)
            r_foul <= '0;
        else if (r_state == LOCKED && w_verdict)
            r_foul <= '0;
        else if (r_state == IDLE)
            r_foul <= r_foul | w_buzz;
    end

    assign w_cand    = w_buzz & ~r_foul;
    assign foul_mask = r_foul;
`else
    assign w_cand = w_buzz;
`endif

    // Next state and verdict decisions; a judge edge outranks a timeout, wrong outranks correct
    always_comb begin
        w_next        = r_state;
        w_set_correct = 1'b0;
        w_set_wrong   = 1'b0;
        unique case (r_state)
            IDLE:   w_next = w_start ? ARMED : IDLE;
            ARMED:  w_next = (|w_cand) ? LOCKED : ARMED;
            LOCKED: begin
                w_next        = w_verdict ? DONE : LOCKED;
                w_set_correct = w_corr & ~w_wrong;
                w_set_wrong   = w_wrong | (w_timeout & ~w_corr);
            end
            DONE:   w_next = w_start ? ARMED : DONE;
        endcase
    end

    // State register, winner latch, countdown and registered verdict pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_player  <= '0;
            r_timer   <= '0;
            r_tick    <= '0;
            r_correct <= 1'b0;
            r_wrong   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_correct <= w_set_correct;
            r_wrong   <= w_set_wrong;
            if (r_state == ARMED && |w_cand) begin
                r_player <= w_win;
                r_timer  <= 8'(ANSWER_SEC);
                r_tick   <= '0;
            end else if (r_state == LOCKED && !w_verdict) begin
                r_tick <= (r_tick == TICK_W'(CLK_HZ - 1)) ? '0 : r_tick + 1'b1;
                if (r_tick == TICK_W'(CLK_HZ - 1) && r_timer != 8'd0)
                    r_timer <= r_timer - 8'd1;
            end else if (r_state == DONE && w_start) begin
                r_player <= '0;
                r_timer  <= '0;
            end
        end
    end

    assign player     = r_player;
    assign if_correct = r_correct;
    assign if_wrong   = r_wrong;
    assign enable     = (r_state == LOCKED);
    assign timer_sec  = r_timer;
    assign state      = r_state;

endmodule

// File: tb/tb_buzz_arbiter.sv
// tb_buzz_arbiter: directed and randomized rounds checked against arithmetic expectations
module tb_buzz_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_btn = 1'b0, correct_btn = 1'b0, wrong_btn = 1'b0;
    logic [N-1:0] buzz = '0;
    logic [N-1:0] player;
    logic         if_correct, if_wrong, enable;
    logic [7:0]   timer_sec;
    logic [1:0]   state;
`ifdef BUZZ_FOUL_EN
    logic [N-1:0] foul_mask;
`endif

    int n_vec = 0;
    int n_err = 0;

    buzz_arbiter #(.N_PLAYERS(N), .CLK_HZ(10), .ANSWER_SEC(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_btn  (start_btn),
        .buzz       (buzz),
        .correct_btn(correct_btn),
        .wrong_btn  (wrong_btn),
        .player     (player),
        .if_correct (if_correct),
        .if_wrong   (if_wrong),
        .enable     (enable),
        .timer_sec  (timer_sec),
        .state      (state)
`ifdef BUZZ_FOUL_EN
        ,
        .foul_mask  (foul_mask)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) begin r = '0; r[i] = 1'b1; end
        return r;
    endfunction

    function automatic int exp_timer(input int k);
        return (3 - k / 10) < 0 ? 0 : 3 - k / 10;
    endfunction

    task automatic press_start();
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        n_vec++;
        if (state !== 2'd1) begin n_err++; $display("FAIL start_to_armed got %0d exp 1", state); end
        n_vec++;
        if (player !== '0 || timer_sec !== 8'd0) begin n_err++; $display("FAIL armed_clear player=%b timer=%0d exp 0/0", player, timer_sec); end
        step(1);
    endtask

    task automatic do_lock(input logic [N-1:0] pat);
        buzz = pat;
        step(3);
        n_vec++;
        if (state !== 2'd2 || enable !== 1'b1) begin n_err++; $display("FAIL lock state=%0d en=%b exp 2/1", state, enable); end
        n_vec++;
        if (player !== lowest(pat)) begin n_err++; $display("FAIL lock_player pat=%b got %b exp %b", pat, player, lowest(pat)); end
        n_vec++;
        if (timer_sec !== 8'd3) begin n_err++; $display("FAIL lock_timer got %0d exp 3", timer_sec); end
        buzz = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_vec++;
        if ({player, if_correct, if_wrong, enable, timer_sec, state} !== '0) begin
            n_err++;
            $display("FAIL reset p=%b c=%b w=%b en=%b t=%0d s=%0d exp all 0", player, if_correct, if_wrong, enable, timer_sec, state);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_idle_ignore();
        buzz = 4'b1010;
        step(4);
        n_vec++;
        if (state !== 2'd0 || player !== '0) begin n_err++; $display("FAIL idle_buzz state=%0d player=%b exp 0/0000", state, player); end
        buzz = '0;
        step(3);
    endtask

    task automatic test_basic_correct();
        press_start();
        step(1);
        start_btn = 1'b1;
        step(3);
        start_btn = 1'b0;
        n_vec++;
        if (state !== 2'd1) begin n_err++; $display("FAIL armed_start_ignored got %0d exp 1", state); end
        step(2);
        do_lock(4'b0100);
        step(2);
        correct_btn = 1'b1;
        step(3);
        n_vec++;
        if (if_correct !== 1'b1 || if_wrong !== 1'b0) begin n_err++; $display("FAIL correct_pulse c=%b w=%b exp 1/0", if_correct, if_wrong); end
        n_vec++;
        if (state !== 2'd3 || enable !== 1'b0 || player !== 4'b0100) begin
            n_err++;
            $display("FAIL correct_done s=%0d en=%b p=%b exp 3/0/0100", state, enable, player);
        end
        correct_btn = 1'b0;
        step(1);
        n_vec++;
        if (if_correct !== 1'b0) begin n_err++; $display("FAIL correct_single got %b exp 0", if_correct); end
        wrong_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_vec++;
            if (if_wrong !== 1'b0 || state !== 2'd3 || player !== 4'b0100) begin
                n_err++;
                $display("FAIL done_judge_ignored w=%b s=%0d p=%b exp 0/3/0100", if_wrong, state, player);
            end
        end
        wrong_btn = 1'b0;
        step(2);
    endtask

    task automatic test_simultaneous_and_both_judges();
        press_start();
        do_lock(4'b0110);
        step(2);
        buzz = 4'b0001;
        step(4);
        n_vec++;
        if (player !== 4'b0010 || state !== 2'd2) begin n_err++; $display("FAIL late_buzz p=%b s=%0d exp 0010/2", player, state); end
        buzz = '0;
        step(2);
        correct_btn = 1'b1;
        wrong_btn   = 1'b1;
        step(3);
        n_vec++;
        if (if_wrong !== 1'b1 || if_correct !== 1'b0) begin n_err++; $display("FAIL both_judges c=%b w=%b exp 0/1", if_correct, if_wrong); end
        correct_btn = 1'b0;
        wrong_btn   = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        press_start();
        do_lock(4'b1000);
        for (int k = 0; k <= 33; k++) begin
            if (if_wrong === 1'b1) pulses++;
            n_vec++;
            if (k <= 30) begin
                if (state !== 2'd2 || timer_sec !== 8'(exp_timer(k)) || if_wrong !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_count k=%0d s=%0d t=%0d w=%b exp 2/%0d/0", k, state, timer_sec, if_wrong, exp_timer(k));
                end
            end else if (k == 31) begin
                if (state !== 2'd3 || if_wrong !== 1'b1 || if_correct !== 1'b0 || timer_sec !== 8'd0) begin
                    n_err++;
                    $display("FAIL timeout_verdict s=%0d w=%b c=%b t=%0d exp 3/1/0/0", state, if_wrong, if_correct, timer_sec);
                end
            end else begin
                if (state !== 2'd3 || if_wrong !== 1'b0 || timer_sec !== 8'd0) begin
                    n_err++;
                    $display("FAIL timeout_after k=%0d s=%0d w=%b t=%0d exp 3/0/0", k, state, if_wrong, timer_sec);
                end
            end
            step(1);
        end
        n_vec++;
        if (pulses != 1) begin n_err++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_reset_mid();
        press_start();
        do_lock(4'b0001);
        step(2);
        rst = 1'b1;
        step(1);
        n_vec++;
        if ({player, if_correct, if_wrong, enable, timer_sec, state} !== '0) begin
            n_err++;
            $display("FAIL reset_mid p=%b c=%b w=%b en=%b t=%0d s=%0d exp all 0", player, if_correct, if_wrong, enable, timer_sec, state);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_vec++;
            if (if_correct !== 1'b0 || if_wrong !== 1'b0 || state !== 2'd0) begin
                n_err++;
                $display("FAIL reset_quiet c=%b w=%b s=%0d exp 0/0/0", if_correct, if_wrong, state);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] pat, win;
        int k, d, v;
        press_start();
        for (int r = 0; r < 12; r++) begin
            pat = N'($urandom_range(1, (1 << N) - 1));
            win = lowest(pat);
            do_lock(pat);
            k = 0;
            d = $urandom_range(2, 12);
            step(d);
            k += d;
            n_vec++;
            if (timer_sec !== 8'(exp_timer(k))) begin n_err++; $display("FAIL rand_timer k=%0d got %0d exp %0d", k, timer_sec, exp_timer(k)); end
            buzz = N'($urandom);
            step(3);
            buzz = '0;
            step(2);
            n_vec++;
            if (player !== win || state !== 2'd2) begin n_err++; $display("FAIL rand_hold p=%b s=%0d exp %b/2", player, state, win); end
            v = $urandom_range(0, 2);
            correct_btn = (v != 1);
            wrong_btn   = (v != 0);
            step(3);
            n_vec++;
            if (if_correct !== (v == 0) || if_wrong !== (v != 0) || state !== 2'd3 || player !== win) begin
                n_err++;
                $display("FAIL rand_verdict v=%0d c=%b w=%b s=%0d p=%b exp %b/%b/3/%b", v, if_correct, if_wrong, state, player, v == 0, v != 0, win);
            end
            correct_btn = 1'b0;
            wrong_btn   = 1'b0;
            step(1);
            n_vec++;
            if (if_correct !== 1'b0 || if_wrong !== 1'b0) begin n_err++; $display("FAIL rand_single c=%b w=%b exp 0/0", if_correct, if_wrong); end
            step(1);
            press_start();
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic_correct();
        test_simultaneous_and_both_judges();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
